spi_master_ctrl: RTL and testbench

Sequences one full-duplex 8-bit SPI transfer per request. It generates SCLK from the system clock through a programmable divider and drives SS_n and MOSI. It samples MISO and returns the received byte with a one-cycle done pulse. It is the controller that schedules the shift/count datapath for all four CPOL/CPHA modes with selectable bit order (LSBFE), and sits between the host register interface and the SPI pins.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_clk_gen.sv | 31 +++
 rtl/spi_master_ctrl.sv | 112 +++++++++++
 tb/tb_spi_master_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared state type, frame constants and bit-order helper for the SPI master.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Ticks 1..16 are SCLK edges; tick 17 closes the frame.
  localparam logic [4:0] EDGES     = 5'd16;
  localparam logic [4:0] DONE_TICK = 5'd17;

  // Bit that leaves the shifter first: bit 0 when LSB first, top bit otherwise.
  function automatic logic first_bit(input logic lsbfe, input logic lsb, input logic msb);
    return lsbfe ? lsb : msb;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one tick every baud_div+1 enabled cycles.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick = en && (cnt == div_q);

  // clr restarts the period and captures the divider for the whole frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (clr) begin
      cnt   <= '0;
      div_q <= baud_div;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: one full-duplex DATA_W-bit frame per accepted start, all CPOL/CPHA modes.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              ss_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  state_t            state;
  logic [4:0]        edge_cnt;
  logic [4:0]        edge_nxt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              cpha_q;
  logic              lsbfe_q;
  logic              tick;
  logic              accept;
  logic              odd;
  logic              sample;
  logic              drive;

  assign accept   = (state == IDLE) && start;
  assign edge_nxt = edge_cnt + 5'd1;
  assign odd      = edge_nxt[0];
  // Odd edges lead. cpha=0 samples on leading and shifts on trailing (the
  // last trailing edge has nothing left to shift); cpha=1 is the reverse.
  assign sample   = cpha_q ? ~odd : odd;
  assign drive    = cpha_q ? odd : (~odd && (edge_nxt != EDGES));

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (state == ACTIVE),
    .clr      (accept),
    .baud_div (baud_div),
    .tick     (tick)
  );

  // Frame sequencer: accept, per-tick SCLK toggling, shifting, and completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpha_q   <= 1'b0;
      lsbfe_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        sclk <= cpol;
        if (accept) begin
          state    <= ACTIVE;
          ss_n     <= 1'b0;
          busy     <= 1'b1;
          edge_cnt <= '0;
          rx_sh    <= '0;
          cpha_q   <= cpha;
          lsbfe_q  <= lsbfe;
          if (!cpha) begin
            // First bit must be on the wire before the leading edge samples it.
            mosi  <= first_bit(lsbfe, tx_data[0], tx_data[DATA_W-1]);
            tx_sh <= lsbfe ? {1'b0, tx_data[DATA_W-1:1]} : {tx_data[DATA_W-2:0], 1'b0};
          end else begin
            tx_sh <= tx_data;
          end
        end
      end else if (tick) begin
        edge_cnt <= edge_nxt;
        if (edge_nxt == DONE_TICK) begin
          // SCLK is already back at its idle level after an even edge count.
          state   <= IDLE;
          ss_n    <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
          rx_data <= rx_sh;
        end else begin
          sclk <= ~sclk;
          if (sample)
            rx_sh <= lsbfe_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
          if (drive) begin
            mosi  <= first_bit(lsbfe_q, tx_sh[0], tx_sh[DATA_W-1]);
            tx_sh <= lsbfe_q ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: frame-level timing model plus directed checks.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsbfe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] baud_div = 8'h00;
  logic       miso;
  logic       sclk, mosi, ss_n, busy, done;
  logic [7:0] rx_data;

  int   ncmp = 0;
  int   nerr = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  logic loop = 1'b1;
  logic [7:0] pat = 8'h00;
  logic miso_pat = 1'b0;

  spi_master_ctrl #(.DIV_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsbfe    (lsbfe),
    .baud_div (baud_div),
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (mosi),
    .ss_n     (ss_n),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data)
  );

  always #5 clk = ~clk;

  assign miso = loop ? mosi : miso_pat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame model ----------------
  // m = posedges since accept; edges passed = m/H; frame ends at m = 17H.
  bit         act = 1'b0;
  int         m = 0;
  int         h = 1;
  logic       cp = 1'b0, ch = 1'b0, lf = 1'b0;
  logic [7:0] mtx = 8'h00, mpat = 8'h00;
  logic       e_sclk = 1'b0, e_mosi = 1'b0, e_ss_n = 1'b1, e_busy = 1'b0, e_done = 1'b0;
  logic [7:0] e_rx = 8'h00;

  // Index of the data bit on the wire after n SCLK edges (-1: none driven yet).
  function automatic int bit_idx(input int n);
    int j;
    if (!ch) j = n / 2;
    else     j = (n == 0) ? -1 : (n - 1) / 2;
    return (j > 7) ? 7 : j;
  endfunction

  // j-th bit in transmission order of a byte.
  function automatic logic nth(input logic [7:0] v, input int j);
    logic [7:0] t;
    t = lf ? (v >> j) : (v >> (7 - j));
    return t[0];
  endfunction

  always @(posedge clk) begin
    int n, j;
    cyc++;
    if (!rst) begin
      act = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0; e_ss_n = 1'b1;
      e_busy = 1'b0; e_done = 1'b0; e_rx = 8'h00;
    end else if (act) begin
      m++;
      if (m == 17 * h) begin
        act = 1'b0; e_done = 1'b1; e_rx = mpat; e_ss_n = 1'b1; e_busy = 1'b0; e_sclk = cp;
      end else begin
        n = m / h;
        e_sclk = cp ^ (n % 2 == 1);
        j = bit_idx(n);
        if (j >= 0) e_mosi = nth(mtx, j);
      end
    end else begin
      e_done = 1'b0;
      e_sclk = cpol;
      if (start) begin
        act = 1'b1; m = 0; h = int'(baud_div) + 1;
        cp = cpol; ch = cpha; lf = lsbfe; mtx = tx_data;
        mpat = loop ? tx_data : pat;
        e_ss_n = 1'b0; e_busy = 1'b1;
        if (!cpha) e_mosi = nth(tx_data, 0);
      end
    end
  end

  // Per-cycle compare, and the fixed MISO pattern presented ahead of each sample edge.
  always @(negedge clk) begin
    int j;
    if (chk_en) begin
      chk("sclk",    sclk,    e_sclk);
      chk("mosi",    mosi,    e_mosi);
      chk("ss_n",    ss_n,    e_ss_n);
      chk("busy",    busy,    e_busy);
      chk("done",    done,    e_done);
      chk("rx_data", rx_data, e_rx);
    end
    if (act) begin
      j = bit_idx(m / h);
      if (j < 0) j = 0;
      miso_pat = nth(mpat, j);
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_xfer(input logic p, input logic a, input logic l, input logic [7:0] d,
                            input logic [7:0] tx, input logic lp, input logic [7:0] pt,
                            output int c0);
    @(negedge clk);
    cpol = p; cpha = a; lsbfe = l; baud_div = d; tx_data = tx; loop = lp; pat = pt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(output int cd);
    cd = -1;
    for (int i = 0; i < 5000; i++) begin
      if (done === 1'b1) begin
        cd = cyc;
        break;
      end
      @(negedge clk);
    end
    if (cd < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int c0, cd, rises, last_rise, gap_bad, dcount;
    logic [7:0] cap;
    logic ps;

    // Reset held 3 cycles with start high: nothing may be accepted.
    rst = 1'b0; start = 1'b1;
    @(negedge clk); chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx",   rx_data, 8'h00);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", ss_n, 1);

    // Mode 0, MSB first, H=2, loopback 0xA5.
    start_xfer(0, 0, 0, 8'd1, 8'hA5, 1, 8'h00, c0);
    cap = 8'h00; rises = 0; last_rise = -1; gap_bad = 0; ps = sclk;
    for (int i = 0; i < 200 && done !== 1'b1; i++) begin
      @(negedge clk);
      if (!ps && sclk) begin
        cap = {cap[6:0], mosi};
        if (rises > 0 && cyc - last_rise != 4) gap_bad++;
        last_rise = cyc;
        rises++;
      end
      ps = sclk;
    end
    wait_done(cd);
    chk("m0_latency", cd - c0, 34);
    chk("m0_rx", rx_data, 8'hA5);
    chk("m0_mosi_bits", cap, 8'hA5);
    chk("m0_rises", rises, 8);
    chk("m0_rise_gap", gap_bad, 0);

    // Mode 3, LSB first, H=1, fixed MISO 0x96.
    start_xfer(1, 1, 1, 8'd0, 8'h3C, 0, 8'h96, c0);
    wait_done(cd);
    chk("m3_latency", cd - c0, 17);
    chk("m3_rx", rx_data, 8'h96);
    @(negedge clk); @(negedge clk);
    chk("m3_idle_sclk", sclk, 1);

    // Mode 1 (LSB first) and mode 2 (MSB first), loopback 0x81, H=3.
    start_xfer(0, 1, 1, 8'd2, 8'h81, 1, 8'h00, c0);
    wait_done(cd);
    chk("m1_latency", cd - c0, 51);
    chk("m1_rx", rx_data, 8'h81);
    @(negedge clk); @(negedge clk);
    chk("m1_idle_sclk", sclk, 0);
    start_xfer(1, 0, 0, 8'd2, 8'h81, 1, 8'h00, c0);
    wait_done(cd);
    chk("m2_rx", rx_data, 8'h81);
    @(negedge clk); @(negedge clk);
    chk("m2_idle_sclk", sclk, 1);

    // start and config disturbed mid-frame: frame must be unaffected.
    start_xfer(0, 0, 1, 8'd1, 8'h5A, 1, 8'h00, c0);
    repeat (10) @(negedge clk);
    start = 1'b1; cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b0; baud_div = 8'd7; tx_data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(cd);
    chk("mid_latency", cd - c0, 34);
    chk("mid_rx", rx_data, 8'h5A);

    // start held through done: immediate second frame.
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; baud_div = 8'd0; tx_data = 8'hC3; loop = 1'b1;
    start = 1'b1;
    wait_done(cd);
    @(negedge clk);
    chk("b2b_ss_n", ss_n, 0);
    chk("b2b_busy", busy, 1);
    start = 1'b0;
    wait_done(cd);
    chk("b2b_rx", rx_data, 8'hC3);

    // Reset landing on tick 9 (H=2): abort, no done, partial byte dropped.
    start_xfer(0, 0, 0, 8'd1, 8'h77, 1, 8'h00, c0);
    repeat (17) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ss_n", ss_n, 1);
    chk("abort_busy", busy, 0);
    chk("abort_sclk", sclk, 0);
    chk("abort_rx",   rx_data, 8'h00);
    rst = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    start_xfer(0, 0, 0, 8'd3, 8'h3A, 1, 8'h00, c0);
    wait_done(cd);
    chk("post_latency", cd - c0, 68);
    chk("post_rx", rx_data, 8'h3A);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
